cv32e40n_apu_req_buffer: RTL and testbench

- Sits between the CV32E40P core APU port and the vector accelerator APU responder.
- Decouples core grant from accelerator grant with a small request FIFO.
- Tracks issued-but-unanswered operations and returns accelerator responses to the core one cycle later, registered.
- Drives mem_master_sel_o while any memory-class op is outstanding at the accelerator.

---
 rtl/cv32e40n_apu_buf_pkg.sv | 16 +
 rtl/cv32e40p_apu_core_pkg.sv | 13 +
 rtl/cv32e40n_apu_fifo.sv | 78 +++++++
 rtl/cv32e40n_apu_req_buffer.sv | 153 +++++++++++++++
 tb/tb_cv32e40n_apu_req_buffer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40n_apu_buf_pkg.sv
// Types shared by the APU request buffer and its FIFO.
//   apu_req_t  : one queued core request (operands, opcode, flags)
//   APU_OP_MEM : op[1:0] encoding that marks a memory-class operation
package cv32e40n_apu_buf_pkg;

    import cv32e40p_apu_core_pkg::*;

    typedef struct packed {
        logic [APU_NARGS_CPU-1:0][31:0] operands;
        logic [APU_WOP_CPU-1:0]         op;
        logic [APU_NDSFLAGS_CPU-1:0]    flags;
    } apu_req_t;

    localparam logic [1:0] APU_OP_MEM = 2'd1;

endpackage

// File: rtl/cv32e40p_apu_core_pkg.sv
// APU interface widths shared by the core and the accelerator side.
//   APU_NARGS_CPU    : number of 32-bit operands per request
//   APU_WOP_CPU      : opcode width
//   APU_NDSFLAGS_CPU : downstream (core -> APU) flag width
//   APU_NUSFLAGS_CPU : upstream (APU -> core) flag width
package cv32e40p_apu_core_pkg;

    localparam int unsigned APU_NARGS_CPU    = 3;
    localparam int unsigned APU_WOP_CPU      = 6;
    localparam int unsigned APU_NDSFLAGS_CPU = 15;
    localparam int unsigned APU_NUSFLAGS_CPU = 5;

endpackage

// File: rtl/cv32e40n_apu_fifo.sv
// Generic synchronous FIFO with a combinational head (first-word view).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : drop all entries at the next edge (wins over push/pop)
//   push_i/data_i : write an entry; accepted when not full, or when full and
//                   popping in the same cycle
//   pop_i         : remove the head entry (ignored when empty)
//   data_o        : current head entry (only meaningful when !empty_o)
//   full_o, empty_o : occupancy flags
module cv32e40n_apu_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    // A 1-entry FIFO still needs a 1-bit pointer to index the array.
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             push_eff;
    logic             pop_eff;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o   = (count_reg == CW'(DEPTH));
    assign empty_o  = (count_reg == '0);
    assign push_eff = push_i && (!full_o || pop_i) && !flush_i;
    assign pop_eff  = pop_i && !empty_o && !flush_i;
    assign data_o   = mem_reg[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_eff) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (pop_eff)  rd_ptr_next = ptr_inc(rd_ptr_reg);
            if (push_eff && !pop_eff) count_next = count_reg + 1'b1;
            else if (!push_eff && pop_eff) count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (push_eff) mem_reg[wr_ptr_reg] <= data_i;
    end

endmodule

// File: rtl/cv32e40n_apu_req_buffer.sv
// Request buffer between the core APU port and the vector accelerator.
//   Core side : apu_req_i/apu_gnt_o with operands/op/flags, responses on
//               apu_rvalid_o/apu_result_o/apu_flags_o (one cycle after acc).
//   Acc side  : acc_req_o/acc_gnt_i presenting the FIFO head, responses on
//               acc_rvalid_i/acc_result_i/acc_flags_i.
//   flush_i          : drop queued, not-yet-issued requests
//   mem_master_sel_o : a memory-class op is outstanding at the accelerator
//   spurious_rsp_o   : pulse after an acc response with nothing outstanding
module cv32e40n_apu_req_buffer
    import cv32e40p_apu_core_pkg::*;
    import cv32e40n_apu_buf_pkg::*;
#(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          apu_req_i,
    output logic                          apu_gnt_o,
    input  logic [APU_NARGS_CPU*32-1:0]   apu_operands_i,
    input  logic [APU_WOP_CPU-1:0]        apu_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]   apu_flags_i,
    output logic                          apu_rvalid_o,
    output logic [31:0]                   apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]   apu_flags_o,
    output logic                          acc_req_o,
    input  logic                          acc_gnt_i,
    output logic [APU_NARGS_CPU*32-1:0]   acc_operands_o,
    output logic [APU_WOP_CPU-1:0]        acc_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]   acc_flags_o,
    input  logic                          acc_rvalid_i,
    input  logic [31:0]                   acc_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]   acc_flags_i,
    output logic                          mem_master_sel_o,
    output logic                          spurious_rsp_o
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    apu_req_t req_in;
    apu_req_t req_head;
    logic     req_full;
    logic     req_empty;
    logic     push;
    logic     issue;
    logic     rsp;
    logic     spurious;
    logic     head_is_mem;
    logic     tag_head;
    logic     tag_full;
    logic     tag_empty;

    logic [OW-1:0]               out_cnt_reg, out_cnt_next;
    logic [OW-1:0]               mem_cnt_reg, mem_cnt_next;
    logic                        mem_sel_reg;
    logic                        rvalid_reg;
    logic                        spurious_reg;
    logic [31:0]                 result_reg;
    logic [APU_NUSFLAGS_CPU-1:0] flags_reg;

    assign req_in.operands = apu_operands_i;
    assign req_in.op       = apu_op_i;
    assign req_in.flags    = apu_flags_i;

    assign apu_gnt_o = !req_full && !flush_i;
    assign push      = apu_req_i && apu_gnt_o;
    assign acc_req_o = !req_empty && (out_cnt_reg < OW'(MAX_OUTSTANDING)) && !flush_i;
    assign issue     = acc_req_o && acc_gnt_i;

    // A response is only real if something is waiting for it.
    assign rsp      = acc_rvalid_i && (out_cnt_reg != '0);
    assign spurious = acc_rvalid_i && (out_cnt_reg == '0);

    assign head_is_mem    = (req_head.op[1:0] == APU_OP_MEM);
    assign acc_operands_o = req_empty ? '0 : req_head.operands;
    assign acc_op_o       = req_empty ? '0 : req_head.op;
    assign acc_flags_o    = req_empty ? '0 : req_head.flags;

    cv32e40n_apu_fifo #(
        .WIDTH ($bits(apu_req_t)),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (issue),
        .data_i  (req_in),
        .data_o  (req_head),
        .full_o  (req_full),
        .empty_o (req_empty)
    );

    // Tags follow issued ops in order so each response knows whether it
    // retires a memory-class op. Occupancy mirrors out_cnt_reg, so the
    // full/empty flags carry no extra information here.
    cv32e40n_apu_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .push_i  (issue),
        .pop_i   (rsp),
        .data_i  (head_is_mem),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    always_comb begin
        out_cnt_next = out_cnt_reg;
        mem_cnt_next = mem_cnt_reg;
        if (issue && !rsp)      out_cnt_next = out_cnt_reg + 1'b1;
        else if (!issue && rsp) out_cnt_next = out_cnt_reg - 1'b1;
        if ((issue && head_is_mem) && !(rsp && tag_head))      mem_cnt_next = mem_cnt_reg + 1'b1;
        else if (!(issue && head_is_mem) && (rsp && tag_head)) mem_cnt_next = mem_cnt_reg - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt_reg  <= '0;
            mem_cnt_reg  <= '0;
            mem_sel_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            spurious_reg <= 1'b0;
            result_reg   <= '0;
            flags_reg    <= '0;
        end else begin
            out_cnt_reg  <= out_cnt_next;
            mem_cnt_reg  <= mem_cnt_next;
            mem_sel_reg  <= (mem_cnt_next != '0);
            rvalid_reg   <= rsp;
            spurious_reg <= spurious;
            if (rsp) begin
                result_reg <= acc_result_i;
                flags_reg  <= acc_flags_i;
            end
        end
    end

    assign apu_rvalid_o     = rvalid_reg;
    assign apu_result_o     = result_reg;
    assign apu_flags_o      = flags_reg;
    assign mem_master_sel_o = mem_sel_reg;
    assign spurious_rsp_o   = spurious_reg;

    logic unused_tag_flags;
    assign unused_tag_flags = tag_full ^ tag_empty;

endmodule

// File: tb/tb_cv32e40n_apu_req_buffer.sv
module tb_cv32e40n_apu_req_buffer;

    import cv32e40p_apu_core_pkg::*;

    logic                        clk_i = 1'b0;
    logic                        rst_ni;
    logic                        flush_i;
    logic                        apu_req_i;
    logic                        apu_gnt_o;
    logic [APU_NARGS_CPU*32-1:0] apu_operands_i;
    logic [APU_WOP_CPU-1:0]      apu_op_i;
    logic [APU_NDSFLAGS_CPU-1:0] apu_flags_i;
    logic                        apu_rvalid_o;
    logic [31:0]                 apu_result_o;
    logic [APU_NUSFLAGS_CPU-1:0] apu_flags_o;
    logic                        acc_req_o;
    logic                        acc_gnt_i;
    logic [APU_NARGS_CPU*32-1:0] acc_operands_o;
    logic [APU_WOP_CPU-1:0]      acc_op_o;
    logic [APU_NDSFLAGS_CPU-1:0] acc_flags_o;
    logic                        acc_rvalid_i;
    logic [31:0]                 acc_result_i;
    logic [APU_NUSFLAGS_CPU-1:0] acc_flags_i;
    logic                        mem_master_sel_o;
    logic                        spurious_rsp_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    cv32e40n_apu_req_buffer #(
        .DEPTH           (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .apu_req_i        (apu_req_i),
        .apu_gnt_o        (apu_gnt_o),
        .apu_operands_i   (apu_operands_i),
        .apu_op_i         (apu_op_i),
        .apu_flags_i      (apu_flags_i),
        .apu_rvalid_o     (apu_rvalid_o),
        .apu_result_o     (apu_result_o),
        .apu_flags_o      (apu_flags_o),
        .acc_req_o        (acc_req_o),
        .acc_gnt_i        (acc_gnt_i),
        .acc_operands_o   (acc_operands_o),
        .acc_op_o         (acc_op_o),
        .acc_flags_o      (acc_flags_o),
        .acc_rvalid_i     (acc_rvalid_i),
        .acc_result_i     (acc_result_i),
        .acc_flags_i      (acc_flags_i),
        .mem_master_sel_o (mem_master_sel_o),
        .spurious_rsp_o   (spurious_rsp_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic core_req(input logic req, input logic [5:0] op, input logic [31:0] base);
        apu_req_i      = req;
        apu_op_i       = op;
        apu_operands_i = {base + 32'd2, base + 32'd1, base};
        apu_flags_i    = 15'(op);
    endtask

    initial begin
        rst_ni         = 1'b0;
        flush_i        = 1'b0;
        apu_req_i      = 1'b0;
        apu_operands_i = '0;
        apu_op_i       = '0;
        apu_flags_i    = '0;
        acc_gnt_i      = 1'b0;
        acc_rvalid_i   = 1'b0;
        acc_result_i   = '0;
        acc_flags_i    = '0;
        #2;

        // Reset values
        check("rst_rvalid", 128'(apu_rvalid_o), 128'd0);
        check("rst_result", 128'(apu_result_o), 128'd0);
        check("rst_flags",  128'(apu_flags_o), 128'd0);
        check("rst_accreq", 128'(acc_req_o), 128'd0);
        check("rst_memsel", 128'(mem_master_sel_o), 128'd0);
        check("rst_spur",   128'(spurious_rsp_o), 128'd0);
        check("rst_gnt",    128'(apu_gnt_o), 128'd1);
        step();
        rst_ni = 1'b1;
        step();

        // Single op
        apu_req_i      = 1'b1;
        apu_op_i       = 6'h00;
        apu_operands_i = {32'd1, 32'd2, 32'd3};
        apu_flags_i    = 15'h0;
        settle();
        check("single_gnt", 128'(apu_gnt_o), 128'd1);
        check("single_nofall", 128'(acc_req_o), 128'd0);
        step();
        apu_req_i = 1'b0;
        acc_gnt_i = 1'b1;
        settle();
        check("single_accreq", 128'(acc_req_o), 128'd1);
        check("single_operands", 128'(acc_operands_o), {32'd0, 32'd1, 32'd2, 32'd3});
        step();
        acc_gnt_i = 1'b0;
        settle();
        check("single_empty_req", 128'(acc_req_o), 128'd0);
        check("single_empty_ops", 128'(acc_operands_o), 128'd0);
        step();
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'hDEAD_BEEF;
        acc_flags_i  = 5'h3;
        settle();
        check("single_rv_early", 128'(apu_rvalid_o), 128'd0);
        step();
        acc_rvalid_i = 1'b0;
        acc_result_i = 32'h0;
        acc_flags_i  = 5'h0;
        check("single_rvalid", 128'(apu_rvalid_o), 128'd1);
        check("single_result", 128'(apu_result_o), 128'hDEAD_BEEF);
        check("single_flags",  128'(apu_flags_o), 128'h3);
        step();
        check("single_rv_drop", 128'(apu_rvalid_o), 128'd0);
        check("single_hold",    128'(apu_result_o), 128'hDEAD_BEEF);

        // Backpressure
        core_req(1'b1, 6'h04, 32'h100);
        settle();
        check("bp_gnt0", 128'(apu_gnt_o), 128'd1);
        step();
        core_req(1'b1, 6'h08, 32'h200);
        settle();
        check("bp_gnt1", 128'(apu_gnt_o), 128'd1);
        check("bp_req_nogrant", 128'(acc_req_o), 128'd1);
        step();
        core_req(1'b1, 6'h0C, 32'h300);
        settle();
        check("bp_gnt2_full", 128'(apu_gnt_o), 128'd0);
        step();
        apu_req_i = 1'b0;
        acc_gnt_i = 1'b1;
        settle();
        check("bp_head0", 128'(acc_op_o), 128'h04);
        step();
        check("bp_gnt_back", 128'(apu_gnt_o), 128'd1);
        check("bp_head1", 128'(acc_op_o), 128'h08);
        check("bp_head1_ops", 128'(acc_operands_o[31:0]), 128'h200);
        check("bp_req1", 128'(acc_req_o), 128'd1);
        step();
        acc_gnt_i = 1'b0;
        settle();
        check("bp_drained", 128'(acc_req_o), 128'd0);
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'h1;
        step();
        acc_result_i = 32'h2;
        step();
        acc_rvalid_i = 1'b0;
        check("bp_rsp2", 128'(apu_result_o), 128'h2);
        step();

        // Outstanding limit: two issues without any response
        acc_gnt_i = 1'b1;
        core_req(1'b1, 6'h10, 32'h400);
        step();
        core_req(1'b1, 6'h14, 32'h500);
        settle();
        check("lim_issue0", 128'(acc_op_o), 128'h10);
        step();
        core_req(1'b1, 6'h18, 32'h600);
        settle();
        check("lim_issue1", 128'(acc_op_o), 128'h14);
        step();
        apu_req_i = 1'b0;
        settle();
        check("lim_stall_req", 128'(acc_req_o), 128'd0);
        check("lim_stall_head", 128'(acc_op_o), 128'h18);
        step();
        check("lim_still", 128'(acc_req_o), 128'd0);
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'h33;
        settle();
        check("lim_same_cycle", 128'(acc_req_o), 128'd0);
        step();
        acc_rvalid_i = 1'b0;
        check("lim_release", 128'(acc_req_o), 128'd1);
        check("lim_rvalid", 128'(apu_rvalid_o), 128'd1);
        step();
        acc_gnt_i = 1'b0;
        settle();
        check("lim_after", 128'(acc_req_o), 128'd0);
        acc_rvalid_i = 1'b1;
        step();
        step();
        acc_rvalid_i = 1'b0;
        step();

        // mem_master_sel tracking
        acc_gnt_i = 1'b1;
        core_req(1'b1, 6'h01, 32'h700);
        step();
        core_req(1'b1, 6'h00, 32'h800);
        settle();
        check("mem_pre", 128'(mem_master_sel_o), 128'd0);
        step();
        apu_req_i = 1'b0;
        check("mem_set", 128'(mem_master_sel_o), 128'd1);
        step();
        acc_gnt_i = 1'b0;
        check("mem_hold", 128'(mem_master_sel_o), 128'd1);
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'h44;
        step();
        check("mem_drop", 128'(mem_master_sel_o), 128'd0);
        acc_result_i = 32'h45;
        step();
        acc_rvalid_i = 1'b0;
        check("mem_stay0", 128'(mem_master_sel_o), 128'd0);
        check("mem_rsp2", 128'(apu_result_o), 128'h45);
        step();

        // Flush of queued, unissued ops
        core_req(1'b1, 6'h20, 32'h900);
        step();
        core_req(1'b1, 6'h24, 32'hA00);
        step();
        flush_i = 1'b1;
        core_req(1'b1, 6'h28, 32'hB00);
        settle();
        check("flush_gnt", 128'(apu_gnt_o), 128'd0);
        check("flush_req", 128'(acc_req_o), 128'd0);
        step();
        flush_i   = 1'b0;
        apu_req_i = 1'b0;
        acc_gnt_i = 1'b1;
        settle();
        check("flush_empty", 128'(acc_req_o), 128'd0);
        check("flush_gnt_back", 128'(apu_gnt_o), 128'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("flush_norv%0d", i), 128'(apu_rvalid_o), 128'd0);
        end
        acc_gnt_i = 1'b0;

        // Spurious response
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'h55;
        step();
        acc_rvalid_i = 1'b0;
        check("spur_pulse", 128'(spurious_rsp_o), 128'd1);
        check("spur_norv", 128'(apu_rvalid_o), 128'd0);
        check("spur_hold", 128'(apu_result_o), 128'h45);
        step();
        check("spur_clear", 128'(spurious_rsp_o), 128'd0);

        // Reset mid-operation
        acc_gnt_i = 1'b1;
        core_req(1'b1, 6'h01, 32'hC00);
        step();
        apu_req_i = 1'b0;
        step();
        check("mid_memsel", 128'(mem_master_sel_o), 128'd1);
        acc_gnt_i = 1'b0;
        core_req(1'b1, 6'h00, 32'hD00);
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'h77;
        step();
        apu_req_i    = 1'b0;
        acc_rvalid_i = 1'b0;
        check("mid_rvalid", 128'(apu_rvalid_o), 128'd1);
        check("mid_accreq", 128'(acc_req_o), 128'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_rvalid", 128'(apu_rvalid_o), 128'd0);
        check("arst_result", 128'(apu_result_o), 128'd0);
        check("arst_accreq", 128'(acc_req_o), 128'd0);
        check("arst_accop",  128'(acc_operands_o), 128'd0);
        check("arst_gnt",    128'(apu_gnt_o), 128'd1);
        step();
        rst_ni = 1'b1;
        step();
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'h88;
        step();
        acc_rvalid_i = 1'b0;
        check("post_rst_spur", 128'(spurious_rsp_o), 128'd1);
        check("post_rst_norv", 128'(apu_rvalid_o), 128'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
